// File: rtl/ppu_vga_scanout.sv
// ppu_vga_scanout
//   Read side of the PPU frame buffer. Generates 640x480@60 VGA timing,
//   reads the 256x240 NES image from vga_mem and shows it 2x-scaled in a
//   centred 512x480 window, with BORDER_COLOR in the remaining visible
//   columns. Signals the PPU when vertical blank starts.
//
// Parameters
//   CLK_DIV       clk cycles per pixel tick (>= 2, so vga_data settles
//                 between the address tick and the colour tick)
//   BORDER_COLOR  RGB332 colour for visible pixels outside the window
//   V_ACTIVE, V_FRONT, V_SYNC, V_BACK
//                 vertical geometry in lines (defaults are 640x480@60)
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   scan_en      scanout enable; low holds counters and outputs idle
//   vga_row      vga_mem read row    (v >> 1)
//   vga_col      vga_mem read column ((h - 64) >> 1)
//   vga_data     vga_mem read data, one clk after the address
//   vga_hsync    horizontal sync, active-low
//   vga_vsync    vertical sync, active-low
//   vga_r/g/b    RGB332 pixel colour
//   vga_de       display enable on active video pixels
//   vblank       vertical counter is in the blanking region
//   frame_start  one-clk pulse when vertical blank begins

module ppu_vga_scanout #(
    parameter int unsigned CLK_DIV      = 2,
    parameter logic [7:0]  BORDER_COLOR = 8'h00,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    output logic [9:0] vga_row,
    output logic [9:0] vga_col,
    input  logic [7:0] vga_data,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       vga_de,
    output logic       vblank,
    output logic       frame_start
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Horizontal geometry, in pixel ticks.
    localparam logic [9:0] H_ACT       = 10'd640;
    localparam logic [9:0] H_SYNC_BEG  = 10'd656;
    localparam logic [9:0] H_SYNC_END  = 10'd752;
    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] WIN_X0      = 10'd64;
    localparam logic [9:0] WIN_X1      = 10'd576;

    // Vertical geometry, in lines.
    localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_VIS  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [9:0]       h;
    logic [9:0]       v;

    // Decode of the current counter position.
    logic in_win, vis, hs_raw, vs_raw;

    // Stage 1: decode registered alongside the memory address.
    logic in_win_d, vis_d, hs_raw_d, vs_raw_d;

    // Stage 2: pin registers.
    logic [7:0] color_q;
    logic [7:0] color_next;
    logic       de_q, hsync_q, vsync_q;
    logic       frame_start_q;

    assign tick = scan_en && (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!scan_en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (!scan_en) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    assign in_win = (h >= WIN_X0) && (h < WIN_X1) && (v < V_ACT);
    assign vis    = (h < H_ACT) && (v < V_ACT);
    assign hs_raw = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
    assign vs_raw = (v >= V_SYNC_BEG) && (v < V_SYNC_END);

    // Address registers only move inside the window, so each NES column is
    // presented for two ticks and each NES row for two lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_row <= '0;
            vga_col <= '0;
        end else if (!scan_en) begin
            vga_row <= '0;
            vga_col <= '0;
        end else if (tick && in_win) begin
            vga_row <= v >> 1;
            vga_col <= (h - WIN_X0) >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_win_d <= 1'b0;
            vis_d    <= 1'b0;
            hs_raw_d <= 1'b0;
            vs_raw_d <= 1'b0;
        end else if (!scan_en) begin
            in_win_d <= 1'b0;
            vis_d    <= 1'b0;
            hs_raw_d <= 1'b0;
            vs_raw_d <= 1'b0;
        end else if (tick) begin
            in_win_d <= in_win;
            vis_d    <= vis;
            hs_raw_d <= hs_raw;
            vs_raw_d <= vs_raw;
        end
    end

    // NOTE: the default assignment comes first so every path drives
    // color_next and no latch is inferred.
    always_comb begin
        color_next = 8'h00;
        if (in_win_d) begin
            color_next = vga_data;
        end else if (vis_d) begin
            color_next = BORDER_COLOR;
        end
    end

    // vga_data already reflects the stage-1 address: it was issued one tick
    // (>= 2 clk) earlier and the memory needs only one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_q <= 8'h00;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (!scan_en) begin
            color_q <= 8'h00;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (tick) begin
            color_q <= color_next;
            de_q    <= vis_d;
            hsync_q <= ~hs_raw_d;
            vsync_q <= ~vs_raw_d;
        end
    end

    // Set by the tick that moves (799, last visible line) into blanking, so
    // the pulse occupies the clk right after that edge, together with vblank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start_q <= 1'b0;
        end else if (!scan_en) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= tick && (h == H_LAST) && (v == V_LAST_VIS);
        end
    end

    // Gating with scan_en makes the idle levels appear as soon as scanout is
    // disabled rather than on the next clock.
    assign vga_hsync   = hsync_q | ~scan_en;
    assign vga_vsync   = vsync_q | ~scan_en;
    assign vga_de      = de_q & scan_en;
    assign vga_r       = scan_en ? color_q[7:5] : 3'd0;
    assign vga_g       = scan_en ? color_q[4:2] : 3'd0;
    assign vga_b       = scan_en ? color_q[1:0] : 2'd0;
    assign frame_start = frame_start_q & scan_en;
    assign vblank      = scan_en && (v >= V_ACT);

endmodule

// File: tb/tb_ppu_vga_scanout.sv
// Bench for ppu_vga_scanout: full 800-tick lines with a shortened vertical
// geometry (4 visible lines, 8 total) so several frames fit in a short run.

module tb_ppu_vga_scanout;

    localparam int unsigned CLK_DIV = 2;
    localparam logic [7:0]  BORDER  = 8'hE0;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VA + VF + VS + VB;
    localparam int HT = 800;
    localparam longint F = longint'(HT) * VT * CLK_DIV;  // clk per frame

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scan_en = 1'b0;
    logic [9:0] vga_row, vga_col;
    logic [7:0] vga_data = 8'h00;
    logic       vga_hsync, vga_vsync, vga_de, vblank, frame_start;
    logic [2:0] vga_r, vga_g;
    logic [1:0] vga_b;

    ppu_vga_scanout #(
        .CLK_DIV      (CLK_DIV),
        .BORDER_COLOR (BORDER),
        .V_ACTIVE     (VA),
        .V_FRONT      (VF),
        .V_SYNC       (VS),
        .V_BACK       (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .vga_row     (vga_row),
        .vga_col     (vga_col),
        .vga_data    (vga_data),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_de      (vga_de),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Frame buffer with one clk read latency.
    logic [7:0] mem [240][256];
    always @(posedge clk)
        vga_data <= (vga_row < 10'd240 && vga_col < 10'd256) ? mem[vga_row][vga_col] : 8'h00;

    // Clock edges seen since scanout (re)started.
    longint n_clk;
    always @(posedge clk or negedge rst)
        if (!rst || !scan_en) n_clk <= 0;
        else                  n_clk <= n_clk + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] rgb;
        logic       vb;
        logic       fs;
        logic [9:0] row;
        logic [9:0] col;
    } obs_t;

    // Expected observables after n clk edges of scanout, from the pixel-tick
    // arithmetic: k ticks done, pins show pixel k-2, address = last window
    // pixel at or before position k-1.
    function automatic obs_t model(input longint n, input logic rst_i, input logic en_i);
        obs_t e;
        int k, q, h, v, p, hp, vp;
        e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 8'h00, vb: 1'b0, fs: 1'b0, row: 10'd0, col: 10'd0};
        if (!rst_i || !en_i) return e;
        k = int'(n / CLK_DIV);
        e.vb = ((k / HT) % VT) >= VA;
        e.fs = (n % CLK_DIV == 0) && (k > 0) && (k % HT == 0) && ((k / HT) % VT == VA);
        if (k >= 2) begin
            q = k - 2;
            h = q % HT;
            v = (q / HT) % VT;
            e.de = (h < 640) && (v < VA);
            e.hs = !(h >= 656 && h < 752);
            e.vs = !(v >= VA + VF && v < VA + VF + VS);
            if (h >= 64 && h < 576 && v < VA) e.rgb = mem[v / 2][(h - 64) / 2];
            else if (e.de)                    e.rgb = BORDER;
        end
        if (k > 64) begin
            p  = k - 1;
            hp = p % HT;
            vp = (p / HT) % VT;
            if (vp < VA && hp >= 64 && hp < 576) begin
                e.row = 10'(vp / 2);
                e.col = 10'((hp - 64) / 2);
            end else if (vp < VA && hp >= 576) begin
                e.row = 10'(vp / 2);
                e.col = 10'd255;
            end else if (vp < VA && vp > 0) begin
                e.row = 10'((vp - 1) / 2);
                e.col = 10'd255;
            end else begin
                e.row = 10'((VA - 1) / 2);
                e.col = 10'd255;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin : pin_checker
        obs_t a;
        a = '{hs: vga_hsync, vs: vga_vsync, de: vga_de, rgb: {vga_r, vga_g, vga_b},
              vb: vblank, fs: frame_start, row: vga_row, col: vga_col};
        check("pins_vs_model", 64'(a), 64'(model(n_clk, rst, scan_en)));
    end

    // Per-frame totals over clk samples 1..F.
    logic stat_en = 1'b0;
    int hs_lo = 0, vs_lo = 0, de_hi = 0, fs_cnt = 0, vb_hi = 0;
    always @(negedge clk)
        if (stat_en && n_clk >= 1 && n_clk <= F) begin
            hs_lo  += int'(!vga_hsync);
            vs_lo  += int'(!vga_vsync);
            de_hi  += int'(vga_de);
            fs_cnt += int'(frame_start);
            vb_hi  += int'(vblank);
        end

    task automatic wait_clk(input longint target, input string name);
        int budget = 40000;
        while (n_clk < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, "_reached"}, 64'(n_clk), 64'(target));
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [7:0] rgb;
        logic       de;
        logic       hs;
        logic       vs;
    } vec_t;

    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[$];
        int   k_fs, vb_run, hd;
        logic vb_prev;
        longint target;

        // Row 0 holds its column index, row 1 a scrambled copy with 8'hFF at
        // its last column.
        vecs.push_back('{0,   0, 8'hE0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{63,  0, 8'hE0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{64,  0, 8'h00, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{65,  0, 8'h00, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{66,  0, 8'h01, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{67,  0, 8'h01, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{575, 0, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{576, 0, 8'hE0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{639, 0, 8'hE0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{640, 0, 8'h00, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{656, 0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{751, 0, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{752, 0, 8'h00, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{574, 1, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{64,  2, 8'hA5, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{572, 2, 8'h5B, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{574, 3, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{575, 3, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{300, 4, 8'h00, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{0,   5, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{700, 6, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0,   7, 8'h00, 1'b0, 1'b1, 1'b1});

        for (int r = 0; r < 240; r++)
            for (int c = 0; c < 256; c++)
                mem[r][c] = 8'h00;

        // Reset, then idle with scan_en low.
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_sync", {62'd0, vga_hsync, vga_vsync}, 64'd3);
        check("idle_rgb_de", 64'({vga_r, vga_g, vga_b, vga_de}), 64'd0);
        check("idle_addr", 64'({vga_row, vga_col}), 64'd0);

        // Directed image, one frame of table vectors and timing totals.
        for (int c = 0; c < 256; c++) begin
            mem[0][c] = 8'(c);
            mem[1][c] = 8'(c) ^ 8'hA5;
        end
        mem[1][255] = 8'hFF;
        #1 scan_en = 1'b1;
        stat_en = 1'b1;
        foreach (vecs[i]) begin
            target = longint'(vecs[i].v * HT + vecs[i].h + 2) * CLK_DIV;
            wait_clk(target, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_h%0d_v%0d", i, vecs[i].h, vecs[i].v),
                  64'({vga_r, vga_g, vga_b, vga_de, vga_hsync, vga_vsync}),
                  64'({vecs[i].rgb, vecs[i].de, vecs[i].hs, vecs[i].vs}));
        end
        wait_clk(F, "frame_end");
        @(negedge clk);
        stat_en = 1'b0;
        check("hsync_low_clks", 64'(hs_lo), 64'(192 * VT));
        check("vsync_low_clks", 64'(vs_lo), 64'(VS * HT * CLK_DIV));
        check("de_high_clks", 64'(de_hi), 64'(1280 * VA));
        check("frame_start_per_frame", 64'(fs_cnt), 64'd1);
        check("vblank_clks", 64'(vb_hi), 64'((VT - VA) * HT * CLK_DIV));

        // Random image, three frames of render handshake.
        #1 scan_en = 1'b0;
        for (int r = 0; r < 240; r++)
            for (int c = 0; c < 256; c++)
                mem[r][c] = 8'($urandom);
        repeat (2) @(negedge clk);
        #1 scan_en = 1'b1;
        k_fs = 0;
        vb_run = 0;
        vb_prev = 1'b0;
        for (longint i = 0; i < 3 * F; i++) begin
            @(negedge clk);
            if (frame_start) begin
                k_fs++;
                check("fs_on_vblank_rise", 64'({vblank, vb_prev}), 64'(2'b10));
            end
            if (vblank) vb_run++;
            else begin
                if (vb_prev) check("vblank_len", 64'(vb_run), 64'((VT - VA) * HT * CLK_DIV));
                vb_run = 0;
            end
            vb_prev = vblank;
        end
        check("fs_count_3frames", 64'(k_fs), 64'd3);

        // Mid-frame disruption: mode 0 drops rst, mode 1 drops scan_en.
        for (int mode = 0; mode < 2; mode++) begin
            @(negedge clk);
            #1 scan_en = 1'b0;
            @(negedge clk);
            #1 scan_en = 1'b1;
            hd = int'($urandom_range(0, 799));
            target = longint'(HT + hd) * CLK_DIV + longint'($urandom_range(0, CLK_DIV - 1));
            wait_clk(target, $sformatf("disrupt%0d_point", mode));
            #1;
            if (mode == 0) rst = 1'b0;
            else           scan_en = 1'b0;
            #1;
            check($sformatf("disrupt%0d_immediate", mode),
                  64'({vga_hsync, vga_vsync, vga_de, vga_r, vga_g, vga_b, frame_start, vblank}),
                  64'({1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
            repeat (3) @(negedge clk);
            check($sformatf("disrupt%0d_addr", mode), 64'({vga_row, vga_col}), 64'd0);
            #1;
            rst = 1'b1;
            scan_en = 1'b1;
            begin
                int budget = 100;
                while (!vga_de && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
            end
            check($sformatf("disrupt%0d_first_de", mode), 64'(n_clk), 64'(2 * CLK_DIV));
            begin
                int budget = 20000;
                while (!frame_start && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
            end
            check($sformatf("disrupt%0d_next_fs", mode), 64'(n_clk), 64'(VA * HT * CLK_DIV));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ppu_vga_scanout.md
# ppu_vga_scanout

Read side of the PPU frame buffer (`vga_mem`). The `ppu_vram_load_fsm` writes rendered NES pixels into `vga_mem`; this block is the other end of that memory. It generates 640x480@60 VGA timing and reads `vga_mem` through its `vga_row`/`vga_col`/`vga_data` port. It 2x-scales the 256x240 NES image into a centred 512x480 window and drives sync and RGB pins. It also tells the PPU when vertical blank starts, so the next frame can be rendered.

## Interface
- `CLK_DIV`, default 2: number of `clk` cycles per pixel tick. Must be ≥2.
- `BORDER_COLOR`, default 8'h00: colour shown in visible columns outside the 512-wide window.
- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `scan_en` in 1: scanout enable; when low, counters and outputs are held idle.
- `vga_row` out 10: `vga_mem` read row (0..239).
- `vga_col` out 10: `vga_mem` read column (0..255).
- `vga_data` in 8: `vga_mem` read data; synchronous, 1 `clk` latency.
- `vga_hsync` out 1: horizontal sync, active-low.
- `vga_vsync` out 1: vertical sync, active-low.
- `vga_r` out 3, `vga_g` out 3, `vga_b` out 2: pixel colour; RGB332 taken from colour bits [7:5], [4:2], [1:0].
- `vga_de` out 1: display-enable, high on active video pixels.
- `vblank` out 1: high while the vertical counter is ≥480.
- `frame_start` out 1: one-`clk` pulse that triggers the PPU render pass.

## Operation
- **Tick divider.** A counter runs 0..CLK_DIV-1. `tick` is asserted on the cycle the divider equals CLK_DIV-1. All counter and pipeline updates below happen only on `tick`.
- **Horizontal counter `h`.** Range 0..799:
  - 0..639 visible
  - 640..655 front porch
  - 656..751 sync
  - 752..799 back porch
  - 799 wraps to 0 and increments `v`.
- **Vertical counter `v`.** Range 0..524:
  - 0..479 visible
  - 480..489 front porch
  - 490..491 sync
  - 492..524 back porch
  - 524 wraps to 0.
- **Window.** The image window is h 64..575 with v 0..479. On a tick, address registers load:
  - `vga_row = v>>1`
  - `vga_col = (h-64)>>1`

  Outside the window the address registers hold their last value.
- **Stage 1 (pipeline).** On the same tick, register:
  - `in_win`
  - `vis` (h<640 and v<480)
  - `hs_raw` (h in 656..751)
  - `vs_raw` (v in 490..491)
- **Stage 2 (pipeline).** On the next tick:
  - `vga_de = vis_d`.
  - Colour is `vga_data` if `in_win_d`, `BORDER_COLOR` if `vis_d` and not `in_win_d`, and 0 otherwise.
  - `vga_hsync = ~hs_raw_d` and `vga_vsync = ~vs_raw_d`.

  `vga_data` is already valid here because CLK_DIV≥2.
- **`vblank`.** Combinational on `v`: `v >= 480`. It is not pipelined.
- **`frame_start`.** Pulses for one `clk` on the tick where the counters move from (799,479) to (0,480).
- **`scan_en` low.** Divider, `h` and `v` are held at 0. `vga_hsync` and `vga_vsync` are driven 1, RGB and `vga_de` are 0, `frame_start` is 0, and `vblank` is 0.
- **`scan_en` rising.** Scanout restarts at (0,0). The first pixel appears on the pins two ticks later.
- **Reset values** (`rst`=0, immediate): every counter and address register is 0, `vga_hsync` and `vga_vsync` are 1, RGB is 0, `vga_de` is 0, `vblank` is 0, `frame_start` is 0. A reset mid-frame restarts at (0,0) with no partial pulses.

## Timing
- Pin output for pixel (h,v) appears 2 ticks after the counters hold (h,v). Sync and DE are delayed by the same 2 ticks, so the relative VGA timing is exact.
- Line length is 800 ticks. Frame length is 525 lines = 420000 ticks = 420000·CLK_DIV `clk` cycles.
- `vga_row`/`vga_col` change only on tick edges inside the window. Each address value is held for 2 ticks horizontally, and each row for 2 lines.
- `frame_start` rises exactly 1 `clk` after the tick that sets v=480, and lasts 1 `clk`.
- `vblank` rises on that same edge and falls when `v` wraps to 0.

## Test plan
- **Reset and idle.** Hold `rst`=0 for 10 clocks, then release with `scan_en`=0 for 100 clocks → `vga_hsync`=`vga_vsync`=1, RGB=0, `vga_de`=0, and `vga_row`=`vga_col`=0 throughout.
- **Line and frame timing.** CLK_DIV=2, `scan_en`=1, one full frame:
  - `vga_hsync` low for 192 clocks of every 1600.
  - `vga_vsync` low for 2 lines (3200 clocks) of every 840000.
  - `vga_de` high for 1280 clocks per line on 480 lines.
  - Exactly one `frame_start` per 840000 clocks.
- **Addressing and scaling.** Load `vga_mem` with data = `col[7:0]` at row 0 → on line 0:
  - `vga_col` steps 0,0,1,1,…,255,255 over h=64..575.
  - Pin R/G/B at h=66 shows colour 8'h01 = R0 G0 B1.
  - h=0..63 and h=576..639 show `BORDER_COLOR` (set to 8'hE0 → R=7).
- **Row mapping.** Write 8'hFF at (row 239, col 255) → lines 478 and 479 at h=574,575 show R=7 G=7 B=3 with `vga_de`=1. Line 477 at the same columns shows the prior row's data.
- **Render handshake.** Count `frame_start` pulses across 3 frames → 3 pulses, each coinciding with `vblank` rising. `vblank` lasts 45 lines (72000 clocks).
- **Mid-frame disruption.**
  - Drop `rst` at line 200, h=300 → outputs take their reset values immediately. After release, the first `vga_de` high occurs at tick 2, and the next `frame_start` arrives only after a full 480 lines.
  - Repeat with `scan_en` deasserted instead of `rst` → same behaviour.
